edge_count_bcd: RTL and testbench

Upstream feeder for the two-digit seven-segment driver. It counts rising edges of an external asynchronous input over a fixed gate window of clock cycles. It then converts the saturated count (0..99) to two BCD digits by repeated subtraction. It presents `tens`/`units` with a one-cycle `load` strobe, matching the display driver's load/tens/units inputs.

---
 rtl/edge_count_pkg.sv | 23 ++
 rtl/edge_sync.sv | 28 ++
 rtl/edge_count_bcd.sv | 145 ++++++++++++++
 tb/tb_edge_count_bcd.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_count_pkg.sv
// Shared types and constants for the edge-count-to-BCD feeder.
// Used by edge_count_bcd and its testbench.
package edge_count_pkg;

  localparam int MAX_COUNT = 99;
  localparam int BCD_W     = 4;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    TENS  = 2'd1,
    UNITS = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    if (v == CNT_W'(MAX_COUNT))
      return v;
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus history flop and rising-edge detect.
// edge_out pulses for one clk per rising edge of async_in.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_out
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign edge_out = r_s2 & ~r_s3;

endmodule

// File: rtl/edge_count_bcd.sv
// Gated edge counter with repeated-subtraction BCD conversion.
// Optional sticky saturation flag: define OVERFLOW_FLAG_EN.
module edge_count_bcd
  import edge_count_pkg::*;
#(
  parameter int UPDATE_PERIOD = 1200,
  parameter int PERIOD_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] units,
  output logic             load
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  logic                w_edge;
  logic                w_win_end;
  logic                w_at_max;
  logic                w_ge10;
  logic [CNT_W-1:0]    w_final;
  state_t              w_next;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_timer;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic [CNT_W-1:0]    r_work;
  logic [BCD_W-1:0]    r_tens_acc;
  logic [BCD_W-1:0]    r_tens;
  logic [BCD_W-1:0]    r_units;
  logic                r_load;

  edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (signal),
    .edge_out (w_edge)
  );

  assign w_win_end = (r_timer >= PERIOD_W'(UPDATE_PERIOD - 1));
  assign w_at_max  = (r_edge_cnt == CNT_W'(MAX_COUNT));
  assign w_ge10    = (r_work >= CNT_W'(10));
  // The closing cycle's edge still belongs to the window
  assign w_final   = w_edge ? sat_inc(r_edge_cnt) : r_edge_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= COUNT;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      COUNT: if (w_win_end) w_next = TENS;
      TENS:  if (!w_ge10)   w_next = UNITS;
      UNITS: w_next = COUNT;
      default: w_next = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer    <= '0;
      r_edge_cnt <= '0;
      r_work     <= '0;
      r_tens_acc <= '0;
      r_tens     <= '0;
      r_units    <= '0;
      r_load     <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        COUNT: begin
          if (w_win_end) begin
            r_timer    <= '0;
            r_edge_cnt <= '0;
            r_work     <= w_final;
            r_tens_acc <= '0;
          end else begin
            r_timer    <= r_timer + 1'b1;
            r_edge_cnt <= w_final;
          end
        end
        TENS: begin
          if (w_ge10) begin
            r_work     <= r_work - CNT_W'(10);
            r_tens_acc <= r_tens_acc + 1'b1;
          end
        end
        UNITS: begin
          r_tens  <= r_tens_acc;
          r_units <= r_work[BCD_W-1:0];
          r_load  <= 1'b1;
        end
        default: begin
          r_timer    <= '0;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

  assign tens  = r_tens;
  assign units = r_units;
  assign load  = r_load;

`ifdef OVERFLOW_FLAG_EN
  logic w_ovf_hit;
  logic r_ovf_sticky;
  logic r_ovf_win;
  logic r_overflow;

  assign w_ovf_hit = w_edge & w_at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_win    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        COUNT: begin
          if (w_win_end) begin
            r_ovf_win    <= r_ovf_sticky | w_ovf_hit;
            r_ovf_sticky <= 1'b0;
          end else if (w_ovf_hit) begin
            r_ovf_sticky <= 1'b1;
          end
        end
        UNITS:   r_overflow <= r_ovf_win;
        default: ;
      endcase
    end
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_edge_count_bcd.sv
// Directed bench for edge_count_bcd: two instances, short and long windows.
// Expected digits and strobe cycles are hand-computed per step.
module tb_edge_count_bcd;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       sig_a, sig_b;
  logic [3:0] tens_a, units_a, tens_b, units_b;
  logic       load_a, load_b;
`ifdef OVERFLOW_FLAG_EN
  logic       ovf_a, ovf_b;
`endif

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  int at, p, c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  edge_count_bcd #(.UPDATE_PERIOD(100), .PERIOD_W(7)) dut_a (
    .clk      (clk),
    .reset    (rst_a),
    .signal   (sig_a),
    .tens     (tens_a),
    .units    (units_a),
    .load     (load_a)
`ifdef OVERFLOW_FLAG_EN
    ,
    .overflow (ovf_a)
`endif
  );

  edge_count_bcd #(.UPDATE_PERIOD(400), .PERIOD_W(9)) dut_b (
    .clk      (clk),
    .reset    (rst_b),
    .signal   (sig_b),
    .tens     (tens_b),
    .units    (units_b),
    .load     (load_b)
`ifdef OVERFLOW_FLAG_EN
    ,
    .overflow (ovf_b)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // n clean pulses, 1 clk high / 1 clk low, starting at this negedge
  task automatic pulses(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) sig_b = 1'b1; else sig_a = 1'b1;
      @(negedge clk);
      if (sel) sig_b = 1'b0; else sig_a = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_load(input bit sel, input int budget,
                           output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel ? load_b : load_a) === 1'b1) begin
        when = cyc;
        return;
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tens", tens_a, 0);
    check("rst_units", units_a, 0);
    check("rst_load", load_a, 0);
    check("rst_load_b", load_b, 0);

    // first window, no edges
    rst_a = 1'b0;
    c0 = cyc;
    wait_load(0, 200, at);
    check("w0_at", at - c0, 102);
    check("w0_tens", tens_a, 0);
    check("w0_units", units_a, 0);

    // 37 edges
    p = at;
    pulses(0, 37);
    wait_load(0, 200, at);
    check("w37_ivl", at - p, 105);
    check("w37_tens", tens_a, 3);
    check("w37_units", units_a, 7);
    @(negedge clk);
    check("load_1cyc", load_a, 0);
    check("hold_tens", tens_a, 3);

    // reset mid-COUNT
    pulses(0, 10);
    rst_a = 1'b1;
    @(negedge clk);
    check("rc_tens", tens_a, 0);
    check("rc_units", units_a, 0);
    check("rc_load", load_a, 0);
    rst_a = 1'b0;
    c0 = cyc;
    pulses(0, 12);
    wait_load(0, 200, at);
    check("rc_at", at - c0, 103);
    check("rc_tens2", tens_a, 1);
    check("rc_units2", units_a, 2);

    // 37 edges, then reset mid-TENS
    p = at;
    pulses(0, 37);
    wait_load(0, 200, at);
    check("w37b_ivl", at - p, 105);
    check("w37b_units", units_a, 7);
    p = at;
    pulses(0, 37);
    wait_until(p + 101);
    rst_a = 1'b1;
    @(negedge clk);
    check("rt_tens", tens_a, 0);
    check("rt_units", units_a, 0);
    check("rt_load", load_a, 0);
    rst_a = 1'b0;
    c0 = cyc;
    wait_load(0, 200, at);
    check("rt_at", at - c0, 102);
    check("rt_units2", units_a, 0);

    // edge landing only in dead time
    p = at;
    wait_until(p + 98);
    sig_a = 1'b1;
    wait_until(p + 100);
    sig_a = 1'b0;
    wait_load(0, 200, at);
    check("dt_ivl", at - p, 102);
    check("dt_units", units_a, 0);
    p = at;
    pulses(0, 5);
    wait_load(0, 200, at);
    check("dt_next_ivl", at - p, 102);
    check("dt_next_units", units_a, 5);

    // edge on last window cycle, held high across boundary
    p = at;
    wait_until(p + 97);
    sig_a = 1'b1;
    wait_load(0, 200, at);
    check("last_ivl", at - p, 102);
    check("last_units", units_a, 1);
    p = at;
    wait_until(p + 50);
    sig_a = 1'b0;
    wait_load(0, 200, at);
    check("held_ivl", at - p, 102);
    check("held_units", units_a, 0);

    // long window: saturation then recovery
    rst_b = 1'b0;
    c0 = cyc;
    pulses(1, 150);
    wait_load(1, 600, at);
    check("sat_at", at - c0, 411);
    check("sat_tens", tens_b, 9);
    check("sat_units", units_b, 9);
`ifdef OVERFLOW_FLAG_EN
    check("sat_ovf", ovf_b, 1);
`endif
    p = at;
    pulses(1, 12);
    wait_load(1, 600, at);
    check("b12_ivl", at - p, 403);
    check("b12_tens", tens_b, 1);
    check("b12_units", units_b, 2);
`ifdef OVERFLOW_FLAG_EN
    check("b12_ovf", ovf_b, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
